// File: rtl/flip_pair_sched.sv
// Pairs buffered bit-flip indices into distinct (flip_i, flip_j) pairs; same-index pairs cancel.
// Define FLIP_SCHED_SVA_EN to compile in the concurrent assertions.
module flip_pair_sched #(
    parameter  int DEPTH = 8,
    parameter  int IDX_W = 5,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [IDX_W-1:0] req_idx,
    output logic             pair_valid,
    input  logic             pair_ready,
    output logic [IDX_W-1:0] flip_i,
    output logic [IDX_W-1:0] flip_j,
    output logic             pending,
    output logic [LVL_W-1:0] level,
    output logic [15:0]      cancel_cnt
);

    logic [IDX_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [IDX_W-1:0] held;
    logic [IDX_W-1:0] head;
    logic             head_valid;
    logic             slot_free;
    logic             push;
    logic             pop;
    logic             do_hold;
    logic             do_cancel;
    logic             do_pair;

    // req_ready depends on registered occupancy only, never on pair_ready.
    assign req_ready  = (level != LVL_W'(DEPTH));
    assign push       = req_valid && req_ready;
    assign head_valid = (level != '0);
    assign head       = mem[rd_ptr];
    assign slot_free  = !pair_valid || pair_ready;

    // Exactly one rule applies to the head each cycle; cancel ignores the output slot.
    assign do_hold   = head_valid && !pending;
    assign do_cancel = head_valid && pending && (head == held);
    assign do_pair   = head_valid && pending && (head != held) && slot_free;
    assign pop       = do_hold || do_cancel || do_pair;

    // NOTE: FIFO storage is not reset; the pointers and level alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= req_idx;
        end
    end

    // NOTE: all state uses non-blocking assignments so every rule sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            held       <= '0;
            pending    <= 1'b0;
            pair_valid <= 1'b0;
            flip_i     <= '0;
            flip_j     <= '0;
            cancel_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase

            if (do_hold) begin
                held    <= head;
                pending <= 1'b1;
            end else if (do_cancel) begin
                pending <= 1'b0;
                if (cancel_cnt != 16'hFFFF) begin
                    cancel_cnt <= cancel_cnt + 16'd1;
                end
            end else if (do_pair) begin
                pending <= 1'b0;
            end

            // flip_i/flip_j keep their last values when the slot drains.
            if (do_pair) begin
                pair_valid <= 1'b1;
                flip_i     <= held;
                flip_j     <= head;
            end else if (pair_ready) begin
                pair_valid <= 1'b0;
            end
        end
    end

`ifdef FLIP_SCHED_SVA_EN
    a_distinct: assert property (@(posedge clk) disable iff (rst)
        pair_valid |-> (flip_i != flip_j));

    a_stable: assert property (@(posedge clk) disable iff (rst)
        (pair_valid && !pair_ready) |=> (pair_valid && $stable(flip_i) && $stable(flip_j)));

    a_no_push_full: assert property (@(posedge clk) disable iff (rst)
        (level == LVL_W'(DEPTH)) |-> !req_ready);

    a_level_bound: assert property (@(posedge clk) disable iff (rst)
        level <= LVL_W'(DEPTH));

    a_reset_quiet: assert property (@(posedge clk)
        rst |-> !pair_valid);
`endif

endmodule
